// File: rtl/axi_slave_reg_connector_pkg.sv
// Shared types for the flat-AXI to struct-AXI connector.
// Contents:
//   - default bus widths
//   - spill register state encoding
//   - AXI4 channel payload structs
//   - request/response struct pair (pulp-platform field layout)
package axi_slave_reg_connector_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned USER_W = 1;

  typedef enum logic [1:0] {
    SPILL_EMPTY = 2'd0,  // no beat held
    SPILL_ONE   = 2'd1,  // output slot holds a beat
    SPILL_FULL  = 2'd2   // output and overflow slots both hold beats
  } spill_state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [USER_W-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } rsp_t;

endpackage

// File: rtl/axi_slave_reg_connector_spill.sv
// Two-slot spill register for one AXI channel.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i/ready_o      input-side handshake, data_i payload
//   valid_o/ready_i      output-side handshake, data_o payload
// BYPASS=1 turns the channel into plain wires.
module axi_spill_reg
  import axi_slave_reg_connector_pkg::*;
#(
  parameter bit  BYPASS = 1'b0,
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o
);

  generate
    if (BYPASS) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk_i ^ rst_ni;
      assign valid_o    = valid_i;
      assign ready_o    = ready_i;
      assign data_o     = data_i;
    end else begin : g_spill
      spill_state_e state;
      data_t        a_data;  // output slot
      data_t        b_data;  // overflow slot
      logic         push;
      logic         pop;

      // Both handshake flags decode the state register only, so neither
      // side sees a combinational path from the other side's ready.
      assign ready_o = (state != SPILL_FULL);
      assign valid_o = (state != SPILL_EMPTY);
      assign data_o  = a_data;
      assign push    = valid_i & ready_o;
      assign pop     = valid_o & ready_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state  <= SPILL_EMPTY;
          a_data <= '0;
          b_data <= '0;
        end else begin
          case (state)
            SPILL_EMPTY: begin
              if (push) begin
                a_data <= data_i;
                state  <= SPILL_ONE;
              end
            end
            SPILL_ONE: begin
              // A draining in the same cycle frees it for the new beat.
              if (push && pop) begin
                a_data <= data_i;
              end else if (push) begin
                b_data <= data_i;
                state  <= SPILL_FULL;
              end else if (pop) begin
                state  <= SPILL_EMPTY;
              end
            end
            SPILL_FULL: begin
              if (pop) begin
                a_data <= b_data;
                state  <= SPILL_ONE;
              end
            end
            default: state <= SPILL_EMPTY;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi_slave_reg_connector.sv
// Flat AXI4 slave port to (axi_req_t, axi_rsp_t) struct pair.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   s_axi_aw*/w*/ar*       flat request channels from the external master
//   s_axi_b*/r*            flat response channels to the external master
//   axi_req_o              request struct toward the downstream slave
//   axi_rsp_i              response struct from the downstream slave
// Each channel is cut by its own spill register.
module axi_slave_reg_connector
  import axi_slave_reg_connector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_W,
  parameter int unsigned ADDR_WIDTH   = ADDR_W,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH     = ID_W,
  parameter int unsigned AWUSER_WIDTH = USER_W,
  parameter int unsigned WUSER_WIDTH  = USER_W,
  parameter int unsigned BUSER_WIDTH  = USER_W,
  parameter int unsigned ARUSER_WIDTH = USER_W,
  parameter int unsigned RUSER_WIDTH  = USER_W,
  parameter bit          BYPASS       = 1'b0,
  parameter type         axi_req_t    = req_t,
  parameter type         axi_rsp_t    = rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output axi_req_t                axi_req_o,
  input  axi_rsp_t                axi_rsp_i
);

  aw_chan_t aw_in, aw_out;
  w_chan_t  w_in, w_out;
  ar_chan_t ar_in, ar_out;
  b_chan_t  b_out;
  r_chan_t  r_out;
  logic     aw_valid, w_valid, ar_valid, b_ready, r_ready;

  always_comb begin
    // atop stays zero: the flat port has no atomic operations.
    aw_in        = '0;
    aw_in.id     = s_axi_awid;
    aw_in.addr   = s_axi_awaddr;
    aw_in.len    = s_axi_awlen;
    aw_in.size   = s_axi_awsize;
    aw_in.burst  = s_axi_awburst;
    aw_in.lock   = s_axi_awlock;
    aw_in.cache  = s_axi_awcache;
    aw_in.prot   = s_axi_awprot;
    aw_in.qos    = s_axi_awqos;
    aw_in.region = s_axi_awregion;
    aw_in.user   = s_axi_awuser;
    w_in.data    = s_axi_wdata;
    w_in.strb    = s_axi_wstrb;
    w_in.last    = s_axi_wlast;
    w_in.user    = s_axi_wuser;
    ar_in.id     = s_axi_arid;
    ar_in.addr   = s_axi_araddr;
    ar_in.len    = s_axi_arlen;
    ar_in.size   = s_axi_arsize;
    ar_in.burst  = s_axi_arburst;
    ar_in.lock   = s_axi_arlock;
    ar_in.cache  = s_axi_arcache;
    ar_in.prot   = s_axi_arprot;
    ar_in.qos    = s_axi_arqos;
    ar_in.region = s_axi_arregion;
    ar_in.user   = s_axi_aruser;
  end

  axi_spill_reg #(.BYPASS(BYPASS), .data_t(aw_chan_t)) i_aw_spill (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(s_axi_awvalid), .ready_o(s_axi_awready), .data_i(aw_in),
    .valid_o(aw_valid), .ready_i(axi_rsp_i.aw_ready), .data_o(aw_out)
  );

  axi_spill_reg #(.BYPASS(BYPASS), .data_t(w_chan_t)) i_w_spill (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(s_axi_wvalid), .ready_o(s_axi_wready), .data_i(w_in),
    .valid_o(w_valid), .ready_i(axi_rsp_i.w_ready), .data_o(w_out)
  );

  axi_spill_reg #(.BYPASS(BYPASS), .data_t(ar_chan_t)) i_ar_spill (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(s_axi_arvalid), .ready_o(s_axi_arready), .data_i(ar_in),
    .valid_o(ar_valid), .ready_i(axi_rsp_i.ar_ready), .data_o(ar_out)
  );

  axi_spill_reg #(.BYPASS(BYPASS), .data_t(b_chan_t)) i_b_spill (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(axi_rsp_i.b_valid), .ready_o(b_ready), .data_i(axi_rsp_i.b),
    .valid_o(s_axi_bvalid), .ready_i(s_axi_bready), .data_o(b_out)
  );

  axi_spill_reg #(.BYPASS(BYPASS), .data_t(r_chan_t)) i_r_spill (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(axi_rsp_i.r_valid), .ready_o(r_ready), .data_i(axi_rsp_i.r),
    .valid_o(s_axi_rvalid), .ready_i(s_axi_rready), .data_o(r_out)
  );

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw       = aw_out;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w        = w_out;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = b_ready;
    axi_req_o.ar       = ar_out;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
  end

  assign s_axi_bid   = b_out.id;
  assign s_axi_bresp = b_out.resp;
  assign s_axi_buser = b_out.user;
  assign s_axi_rid   = r_out.id;
  assign s_axi_rdata = r_out.data;
  assign s_axi_rresp = r_out.resp;
  assign s_axi_rlast = r_out.last;
  assign s_axi_ruser = r_out.user;

endmodule
